// File: rtl/vmem_fb.sv
// Double-buffered, writable video memory with integer pixel scaling.
// Producer writes and hardware clears target the back buffer; swaps happen on frame_start.
module vmem_fb #(
    parameter int                H_RES      = 640,
    parameter int                V_RES      = 480,
    parameter int                SCALE_LOG2 = 0,
    parameter int                PIX_W      = 24,
    parameter logic [PIX_W-1:0]  CLR_COLOR  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       h_addr,
    input  logic [9:0]       v_addr,
    output logic [PIX_W-1:0] vga_data,
    input  logic             frame_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             swap_req,
    input  logic             clr_req,
    output logic             front_sel,
    output logic             swap_pending,
    output logic             busy
);

    localparam int FB_W  = H_RES >> SCALE_LOG2;
    localparam int FB_H  = V_RES >> SCALE_LOG2;
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0] H_LIM   = 32'(H_RES);
    localparam logic [31:0] V_LIM   = 32'(V_RES);
    localparam logic [31:0] FBW_LIM = 32'(FB_W);
    localparam logic [31:0] FBH_LIM = 32'(FB_H);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    logic [PIX_W-1:0] mem [2][DEPTH];

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             clr_tgt_q, clr_tgt_d;
    logic             front_sel_q, front_sel_d;
    logic             swap_pending_q, swap_pending_d;
    logic [PIX_W-1:0] vga_data_q, vga_data_d;

    logic [9:0]       fx, fy;
    logic             rd_in_rng;
    logic [AW-1:0]    rd_addr;
    logic             wr_in_rng;
    logic [AW-1:0]    wr_addr;
    logic             do_swap;

    logic             mem_we;
    logic             mem_sel;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_wdata;

    // Read path: scale screen coordinates down, blank anything off the visible area.
    always_comb begin
        fx        = h_addr >> SCALE_LOG2;
        fy        = v_addr >> SCALE_LOG2;
        rd_in_rng = (32'(h_addr) < H_LIM) && (32'(v_addr) < V_LIM) &&
                    (32'(fx) < FBW_LIM) && (32'(fy) < FBH_LIM);
        rd_addr   = AW'(AW'(fy) * AW'(FB_W) + AW'(fx));
        vga_data_d = '0;
        if (rd_in_rng) begin
            vga_data_d = mem[front_sel_q][rd_addr];
        end
    end

    always_comb begin
        wr_in_rng = (32'(wr_x) < FBW_LIM) && (32'(wr_y) < FBH_LIM);
        wr_addr   = AW'(AW'(wr_y) * AW'(FB_W) + AW'(wr_x));
    end

    // A swap waits until no clear is running so the front buffer is never mid-clear.
    always_comb begin
        do_swap        = frame_start && swap_pending_q && (state_q != CLEAR);
        front_sel_d    = front_sel_q ^ do_swap;
        swap_pending_d = do_swap ? 1'b0 : (swap_pending_q | swap_req);
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_tgt_d = clr_tgt_q;
        mem_we    = 1'b0;
        mem_sel   = ~front_sel_q;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            IDLE: begin
                if (wr_valid && wr_in_rng) begin
                    mem_we = 1'b1;
                end
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    // Follow a swap taken this same cycle: clear the new back buffer.
                    clr_tgt_d = ~front_sel_d;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_sel   = clr_tgt_q;
                mem_addr  = clr_cnt_q;
                mem_wdata = CLR_COLOR;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            clr_cnt_q      <= '0;
            clr_tgt_q      <= 1'b0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            vga_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            clr_tgt_q      <= clr_tgt_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            vga_data_q     <= vga_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_sel][mem_addr] <= mem_wdata;
        end
    end

    assign busy         = (state_q == CLEAR);
    assign wr_ready     = (state_q != CLEAR);
    assign front_sel    = front_sel_q;
    assign swap_pending = swap_pending_q;
    assign vga_data     = vga_data_q;

endmodule
